// File: rtl/seven_segment_scan.sv
// seven_segment_scan
// Time-multiplexed driver for a common-anode seven-segment display with
// double-buffered contents, leading-zero blanking, per-digit blink and
// per-digit decimal points.
//
// Ports
//   clk            : single clock, all state updates on its rising edge
//   reset          : asynchronous active-low reset
//   value          : 4*NUM_DIGITS hex nibbles, nibble i -> digit i (digit 0 = LSB)
//   dp             : per-digit decimal point enable (1 = lit)
//   blink          : per-digit blink enable
//   load           : strobe capturing value/dp/blink into the pending set
//   enable         : 0 turns every digit off; scanning keeps running
//   catodes        : active-low segments, bit 7 = DP, bits 6:0 = g..a
//   anodes         : active-low digit select
//   update_pending : high while a loaded set waits for the next frame boundary
//   frame_done     : one-cycle pulse following each frame-boundary tick
//
// Handshake: there is no valid/ready pair. load is a fire-and-forget strobe;
// update_pending reports that the captured set has not reached the display yet.
module seven_segment_scan #(
  parameter int NUM_DIGITS    = 8,
  parameter int REFRESH_LIMIT = 100000,
  parameter int BLINK_FRAMES  = 64,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic                    load,
  input  logic                    enable,
  output logic [7:0]              catodes,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic                    update_pending,
  output logic                    frame_done
);

  localparam int CW = (REFRESH_LIMIT > 1) ? $clog2(REFRESH_LIMIT) : 1;
  localparam int IW = (NUM_DIGITS > 1)    ? $clog2(NUM_DIGITS)    : 1;
  localparam int FW = (BLINK_FRAMES > 1)  ? $clog2(BLINK_FRAMES)  : 1;

  logic [CW-1:0]           tick_cnt;
  logic [IW-1:0]           idx;
  logic [FW-1:0]           frame_cnt;
  logic                    phase;

  logic [4*NUM_DIGITS-1:0] pend_val, act_val, act_val_nxt;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp, act_dp_nxt;
  logic [NUM_DIGITS-1:0]   pend_blk, act_blk, act_blk_nxt;

  logic                    tick, boundary, phase_nxt;
  logic [IW-1:0]           disp_idx;
  logic [3:0]              nib;
  logic                    dp_bit, blk_bit, upper_zero, blank, off;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic [7:0]              cat_nxt;

  always_comb begin
    tick     = (tick_cnt == CW'(REFRESH_LIMIT - 1));
    boundary = tick && (idx == IW'(NUM_DIGITS - 1));

    // The active set is swapped on the boundary edge, and slot 0 of the new
    // frame is registered on that same edge, so decode from the post-swap set.
    act_val_nxt = act_val;
    act_dp_nxt  = act_dp;
    act_blk_nxt = act_blk;
    if (boundary) begin
      if (load) begin
        act_val_nxt = value;
        act_dp_nxt  = dp;
        act_blk_nxt = blink;
      end else begin
        act_val_nxt = pend_val;
        act_dp_nxt  = pend_dp;
        act_blk_nxt = pend_blk;
      end
    end

    phase_nxt = phase ^ (boundary && (frame_cnt == FW'(BLINK_FRAMES - 1)));

    if (!tick)         disp_idx = idx;
    else if (boundary) disp_idx = '0;
    else               disp_idx = idx + IW'(1);

    // Walk from the top digit down so upper_zero means "this nibble and all
    // above it are zero" when the displayed digit is reached.
    upper_zero = 1'b1;
    blank      = 1'b0;
    nib        = 4'h0;
    dp_bit     = 1'b0;
    blk_bit    = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (act_val_nxt[4*i +: 4] == 4'h0);
      if (IW'(i) == disp_idx) begin
        nib     = act_val_nxt[4*i +: 4];
        dp_bit  = act_dp_nxt[i];
        blk_bit = act_blk_nxt[i];
        blank   = (BLANK_LEADING != 0) && (i > 0) && upper_zero;
      end
    end

    off = !enable || blank || (phase_nxt && blk_bit);

    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase

    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_nxt[i] = off || (IW'(i) != disp_idx);
    end
    cat_nxt = {~dp_bit, seg};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt       <= '0;
      idx            <= '0;
      frame_cnt      <= '0;
      phase          <= 1'b0;
      pend_val       <= '0;
      pend_dp        <= '0;
      pend_blk       <= '0;
      act_val        <= '0;
      act_dp         <= '0;
      act_blk        <= '0;
      update_pending <= 1'b0;
      frame_done     <= 1'b0;
      anodes         <= '1;
      catodes        <= 8'hFF;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
      if (tick) idx <= boundary ? '0 : idx + IW'(1);
      if (boundary) begin
        frame_cnt <= (frame_cnt == FW'(BLINK_FRAMES - 1)) ? '0 : frame_cnt + FW'(1);
      end
      phase   <= phase_nxt;
      act_val <= act_val_nxt;
      act_dp  <= act_dp_nxt;
      act_blk <= act_blk_nxt;
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp;
        pend_blk <= blink;
      end
      // A load landing on the boundary went straight to the active set.
      if (boundary)  update_pending <= 1'b0;
      else if (load) update_pending <= 1'b1;
      frame_done <= boundary;
      // Outputs are re-registered every cycle so enable acts on the next edge.
      anodes     <= an_nxt;
      catodes    <= cat_nxt;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan.sv
module tb_seven_segment_scan;

  localparam int N = 4;
  localparam int R = 4;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp, blink;
  logic        load, enable;
  logic [7:0]  catodes;
  logic [3:0]  anodes;
  logic        update_pending, frame_done;

  seven_segment_scan #(
    .NUM_DIGITS(N), .REFRESH_LIMIT(R), .BLINK_FRAMES(B), .BLANK_LEADING(1)
  ) dut (
    .clk(clk), .reset(reset), .value(value), .dp(dp), .blink(blink),
    .load(load), .enable(enable), .catodes(catodes), .anodes(anodes),
    .update_pending(update_pending), .frame_done(frame_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];

  typedef struct {
    logic [15:0]       v;
    logic [3:0]        d;
    logic [3:0][11:0]  exp;  // per slot {anodes, catodes}
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [7:0] t;
    case (n)
      4'h0: t = 8'hC0; 4'h1: t = 8'hF9; 4'h2: t = 8'hA4; 4'h3: t = 8'hB0;
      4'h4: t = 8'h99; 4'h5: t = 8'h92; 4'h6: t = 8'h82; 4'h7: t = 8'hF8;
      4'h8: t = 8'h80; 4'h9: t = 8'h90; 4'hA: t = 8'h88; 4'hB: t = 8'h83;
      4'hC: t = 8'hC6; 4'hD: t = 8'hA1; 4'hE: t = 8'h86; default: t = 8'h8E;
    endcase
    return t[6:0];
  endfunction

  function automatic logic [11:0] model_slot(input logic [15:0] v, input logic [3:0] d, input int i);
    logic [15:0] upper;
    logic [3:0]  an;
    upper = v >> (4 * i);
    an = 4'hF;
    if (!(i > 0 && upper == 16'h0)) an[i] = 1'b0;
    return {an, ~d[i], seg_of(v[4*i +: 4])};
  endfunction

  // driver tasks
  task automatic load_vec(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp = d; blink = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_fd(input string name);
    int k;
    k = 0;
    while (frame_done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (frame_done !== 1'b1) chk({name, "_timeout"}, 32'(frame_done), 32'd1);
  endtask

  task automatic check_frame(input string name);
    logic [11:0] e;
    for (int s = 0; s < N; s++) begin
      if (s > 0) repeat (R) @(negedge clk);
      if (exp_q.size() == 0) begin
        chk({name, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("%s_an%0d", name, s), 32'(anodes), 32'(e[11:8]));
        if (e[11:8] != 4'hF) chk($sformatf("%s_cat%0d", name, s), 32'(catodes), 32'(e[7:0]));
      end
    end
  endtask

  initial begin
    logic [15:0] rv;
    logic [3:0]  rd;

    vecs[0] = '{16'h12AF, 4'b0000, {12'h7F9, 12'hBA4, 12'hD88, 12'hE8E}};
    vecs[1] = '{16'h0005, 4'b0000, {12'hF00, 12'hF00, 12'hF00, 12'hE92}};
    vecs[2] = '{16'h3004, 4'b1010, {12'h730, 12'hBC0, 12'hD40, 12'hE99}};
    vecs[3] = '{16'h0B0C, 4'b0001, {12'hF00, 12'hB83, 12'hDC0, 12'hE46}};
    vecs[4] = '{16'hE7D6, 4'b1111, {12'h706, 12'hB78, 12'hD21, 12'hE02}};
    vecs[5] = '{16'h0000, 4'b0000, {12'hF00, 12'hF00, 12'hF00, 12'hEC0}};
    vecs[6] = '{16'h0090, 4'b0100, {12'hF00, 12'hF00, 12'hD90, 12'hEC0}};

    reset = 1'b0; value = '0; dp = '0; blink = '0; load = 1'b0; enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(anodes), 32'hF);
    chk("rst_cat", 32'(catodes), 32'hFF);
    chk("rst_upd", 32'(update_pending), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // table vectors
    for (int i = 0; i < 7; i++) begin
      load_vec(vecs[i].v, vecs[i].d, 4'b0000);
      wait_fd($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_upd", i), 32'(update_pending), 32'd0);
      for (int s = 0; s < N; s++) exp_q.push_back(vecs[i].exp[s]);
      check_frame($sformatf("vec%0d", i));
    end

    // random vectors through the model
    for (int i = 0; i < 4; i++) begin
      rv = 16'($urandom) >> (4 * $urandom_range(0, 3));
      rd = 4'($urandom_range(0, 15));
      load_vec(rv, rd, 4'b0000);
      wait_fd($sformatf("rnd%0d", i));
      for (int s = 0; s < N; s++) exp_q.push_back(model_slot(rv, rd, s));
      check_frame($sformatf("rnd%0d", i));
    end

    // mid-frame load, latest wins, old frame completes
    load_vec(16'h12AF, 4'b0000, 4'b0000);
    wait_fd("mid_sync");
    chk("mid_s0_an", 32'(anodes), 32'hE);
    chk("mid_s0_cat", 32'(catodes), 32'h8E);
    repeat (5) @(negedge clk);
    load_vec(16'h4321, 4'b0000, 4'b0000);
    chk("mid_upd1", 32'(update_pending), 32'd1);
    chk("mid_s1_an", 32'(anodes), 32'hD);
    chk("mid_s1_cat", 32'(catodes), 32'h88);
    repeat (3) @(negedge clk);
    load_vec(16'h4322, 4'b0000, 4'b0000);
    chk("mid_s2_an", 32'(anodes), 32'hB);
    chk("mid_s2_cat", 32'(catodes), 32'hA4);
    chk("mid_upd2", 32'(update_pending), 32'd1);
    repeat (2) @(negedge clk);
    chk("mid_s3_an", 32'(anodes), 32'h7);
    chk("mid_s3_cat", 32'(catodes), 32'hF9);
    chk("mid_upd3", 32'(update_pending), 32'd1);
    chk("mid_fd_lo", 32'(frame_done), 32'd0);
    repeat (3) @(negedge clk);
    chk("mid_fd_pre", 32'(frame_done), 32'd0);
    @(negedge clk);
    chk("mid_fd", 32'(frame_done), 32'd1);
    chk("mid_upd_clr", 32'(update_pending), 32'd0);
    chk("mid_new_an", 32'(anodes), 32'hE);
    chk("mid_new_cat", 32'(catodes), 32'hA4);
    @(negedge clk);
    chk("mid_fd_pulse", 32'(frame_done), 32'd0);

    // load coinciding with the boundary tick
    repeat (14) @(negedge clk);
    load_vec(16'h00A7, 4'b0000, 4'b0000);
    chk("bnd_fd", 32'(frame_done), 32'd1);
    chk("bnd_upd", 32'(update_pending), 32'd0);
    chk("bnd_an", 32'(anodes), 32'hE);
    chk("bnd_cat", 32'(catodes), 32'hF8);
    repeat (4) @(negedge clk);
    chk("bnd_s1_an", 32'(anodes), 32'hD);
    chk("bnd_s1_cat", 32'(catodes), 32'h88);

    // enable off then on, mid-slot
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("en_off_an", 32'(anodes), 32'hF);
    enable = 1'b1;
    @(negedge clk);
    chk("en_on_an", 32'(anodes), 32'hD);
    chk("en_on_cat", 32'(catodes), 32'h88);
    repeat (8) @(negedge clk);
    chk("en_fd_pre", 32'(frame_done), 32'd0);
    @(negedge clk);
    chk("en_fd", 32'(frame_done), 32'd1);
    chk("en_s0_an", 32'(anodes), 32'hE);

    // asynchronous reset mid-slot
    #2 reset = 1'b0;
    #1;
    chk("arst_an", 32'(anodes), 32'hF);
    chk("arst_cat", 32'(catodes), 32'hFF);
    chk("arst_fd", 32'(frame_done), 32'd0);
    repeat (2) @(negedge clk);
    chk("arst_hold_an", 32'(anodes), 32'hF);
    reset = 1'b1;
    @(negedge clk);
    load_vec(16'h0008, 4'b0001, 4'b0001);
    chk("rel_upd", 32'(update_pending), 32'd1);
    chk("rel_an_d0", 32'(anodes), 32'hE);
    chk("rel_cat_d0", 32'(catodes), 32'hC0);
    @(negedge clk);
    chk("rel_an_c3", 32'(anodes), 32'hE);
    @(negedge clk);
    chk("rel_tick4_an", 32'(anodes), 32'hF);
    repeat (11) @(negedge clk);
    chk("rel_fd_pre", 32'(frame_done), 32'd0);
    chk("rel_upd_pre", 32'(update_pending), 32'd1);
    @(negedge clk);
    chk("rel_fd", 32'(frame_done), 32'd1);
    chk("rel_upd_clr", 32'(update_pending), 32'd0);

    // blink: phase after boundary f is (f / B) % 2
    for (int f = 1; f <= 8; f++) begin
      if (f > 1) repeat (16) @(negedge clk);
      chk($sformatf("blk%0d_fd", f), 32'(frame_done), 32'd1);
      if (((f / B) % 2) == 0) begin
        chk($sformatf("blk%0d_an", f), 32'(anodes), 32'hE);
        chk($sformatf("blk%0d_cat", f), 32'(catodes), 32'h00);
      end else begin
        chk($sformatf("blk%0d_an", f), 32'(anodes), 32'hF);
      end
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seven_segment_scan.md
SEVEN_SEGMENT_SCAN -- requirements
Module: seven_segment_scan

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 8, meaning the number of multiplexed digits, legal range 1..8.
REQ-002 The block SHALL have parameter REFRESH_LIMIT, default 100000, meaning the clk cycles per digit slot, minimum 1.
REQ-003 The block SHALL have parameter BLINK_FRAMES, default 64, meaning the full scan frames per blink half-period, minimum 1.
REQ-004 The block SHALL have parameter BLANK_LEADING, default 1, where 1 enables leading-zero blanking.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL be updated on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, an asynchronous active-low reset (0 = reset asserted).
REQ-007 The block SHALL have port value, input, 4*NUM_DIGITS bits, hex nibbles where nibble i drives digit i and digit 0 is the LSB.
REQ-008 The block SHALL have port dp, input, NUM_DIGITS bits, where bit i = 1 lights the decimal point of digit i.
REQ-009 The block SHALL have port blink, input, NUM_DIGITS bits, where bit i = 1 makes digit i blink.
REQ-010 The block SHALL have port load, input, 1 bit, a strobe that captures value, dp and blink.
REQ-011 The block SHALL have port enable, input, 1 bit, where 0 turns all digits off.
REQ-012 The block SHALL have port catodes, output, 8 bits, active-low: bit 7 is DP and bits 6:0 are segments g..a.
REQ-013 The block SHALL have port anodes, output, NUM_DIGITS bits, active-low digit select.
REQ-014 The block SHALL have port update_pending, output, 1 bit, high while a loaded value awaits a frame boundary.
REQ-015 The block SHALL have port frame_done, output, 1 bit, a one-cycle pulse at the end of each full scan.

Function
REQ-016 The block SHALL run a tick counter 0..REFRESH_LIMIT-1; a tick SHALL occur on the cycle the counter equals REFRESH_LIMIT-1, and the counter SHALL then wrap to 0.
REQ-017 On each tick, the digit index SHALL advance 0,1,..,NUM_DIGITS-1 and then wrap to 0; catodes and anodes SHALL be registered on that same edge for the new index.
REQ-018 The block SHALL keep two register sets for value, dp and blink: a pending set and an active set. Decoding SHALL use only the active set.
REQ-019 When load=1, the block SHALL write the pending set and set update_pending on the next edge; a later load while pending SHALL overwrite it (latest wins).
REQ-020 At a frame boundary (a tick where the index wraps to 0), the pending set SHALL copy to the active set and update_pending SHALL clear.
REQ-021 If load=1 coincides with a frame-boundary tick, the inputs SHALL go directly to the active set and update_pending SHALL be 0 afterwards.
REQ-022 frame_done SHALL be 1 for exactly the cycle following a frame-boundary tick, and 0 otherwise.
REQ-023 The segment code for nibbles 0..F SHALL be bits 6:0 of C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E (hex). catodes[7] SHALL equal ~dp[index].
REQ-024 The anode pattern SHALL be all-ones except bit index = 0, unless the digit is off per REQ-025 to REQ-027, in which case it SHALL be all-ones.
REQ-025 With BLANK_LEADING=1, digit i>0 SHALL be off if active nibbles i..NUM_DIGITS-1 are all zero. Digit 0 SHALL never be blanked by this rule.
REQ-026 A blink phase bit SHALL toggle every BLINK_FRAMES frame boundaries; while the phase is 1, digits with active blink=1 SHALL be off.
REQ-027 With enable=0, anodes SHALL go all-ones on the next edge while counters and loading continue. Re-enabling SHALL resume at the current index.
REQ-028 NUM_DIGITS=1 SHALL make every tick a frame boundary. REFRESH_LIMIT=1 SHALL make every cycle a tick.

Reset
REQ-029 While reset=0, the block SHALL asynchronously force: counters, index and blink phase to 0; pending and active sets to 0; update_pending=0; frame_done=0; anodes all-ones; catodes=FF.
REQ-030 Reset deasserted mid-frame SHALL restart scanning at digit 0, with the first tick REFRESH_LIMIT cycles after release.

Verification (NUM_DIGITS=4, REFRESH_LIMIT=4, BLINK_FRAMES=2)
REQ-031 Load value=16'h12AF, dp=0, then run one frame -> anodes go E,D,B,7 with catodes 8E,88,A4,F9, one per tick.
REQ-032 Load value=16'h0005 with BLANK_LEADING=1 -> slot 0 shows anodes E and catodes 92, and slots 1..3 show anodes F.
REQ-033 Load mid-frame -> update_pending=1 until the boundary, the old value completes its frame, and the new value appears from slot 0; frame_done pulses once per 16 cycles.
REQ-034 Set blink=4'b0001 and dp=4'b0001 -> digit 0 shows catodes with bit7=0 for 2 frames, is off for 2 frames, and repeats.
REQ-035 Assert reset=0 asynchronously mid-slot -> anodes=F and catodes=FF immediately; after release, the first tick lands at cycle 4 on digit 0.
